// File: rtl/spike_event_fifo_if.sv
// spike_event_fifo_if: valid/ready readout bus carrying the head event timestamp.
//   out_valid  head entry present (driven by the FIFO)
//   out_ts     head timestamp (driven by the FIFO)
//   out_ready  consumer accepts the head entry (driven by the reader)
interface spike_event_fifo_if #(parameter int TS_WIDTH = 16);
  logic out_valid;
  logic out_ready;
  logic [TS_WIDTH-1:0] out_ts;
  modport master(output out_valid, output out_ts, input out_ready);
  modport slave(input out_valid, input out_ts, output out_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: timestamps detector spikes and buffers them in a FWFT FIFO with overflow counting.
//   clk, rst (sync, active-high); spike_in event pulse; clr_drop clears drop_cnt/overflow;
//   bus (master) out_valid/out_ts/out_ready readout; level entries stored; drop_cnt saturating
//   loss count; overflow sticky loss flag. Define SPIKE_FIFO_DROP_OLDEST_EN to keep the newest
//   DEPTH events on overflow instead of discarding the incoming one.
module spike_event_fifo #(
  parameter int TS_WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic spike_in,
  input  logic clr_drop,
  spike_event_fifo_if.master bus,
  output logic [AW:0] level,
  output logic [7:0] drop_cnt,
  output logic overflow
);
  logic [TS_WIDTH-1:0] mem [DEPTH];
  logic [TS_WIDTH-1:0] ts;
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, pop, drop, push, rd_adv;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    pop = !empty && bus.out_ready;
    drop = spike_in && full && !pop;
`ifdef SPIKE_FIFO_DROP_OLDEST_EN
    push = spike_in;
    rd_adv = pop || drop;
`else
    push = spike_in && !drop;
    rd_adv = pop;
`endif
  end
  assign bus.out_valid = !empty;
  assign bus.out_ts = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level = wr_ptr - rd_ptr;
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      ts <= ts + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd_adv) rd_ptr <= rd_ptr + 1'b1;
      drop_cnt <= clr_drop ? {7'd0, drop} : drop_cnt + {7'd0, drop && drop_cnt != 8'hff};
      overflow <= (overflow && !clr_drop) || drop;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr[AW-1:0]] <= ts;
endmodule

// File: tb/tb_spike_event_fifo.sv
// tb_spike_event_fifo: directed self-checking bench for spike_event_fifo (TS_WIDTH=4, DEPTH=8).
module tb_spike_event_fifo;
  localparam int TW = 4;
  localparam int DEPTH = 8;
`ifdef SPIKE_FIFO_DROP_OLDEST_EN
  localparam int OLD = 2;
`else
  localparam int OLD = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spike_in = 1'b0;
  logic clr_drop = 1'b0;
  logic [3:0] level;
  logic [7:0] drop_cnt;
  logic overflow;
  int n_cmp = 0;
  int n_err = 0;
  spike_event_fifo_if #(.TS_WIDTH(TW)) bus();
  spike_event_fifo #(.TS_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .clr_drop(clr_drop),
    .bus(bus), .level(level), .drop_cnt(drop_cnt), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    spike_in = 1'b0;
    clr_drop = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic drain(input string tag, input int first, input int n);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), int'(bus.out_ts), (first + i) % 16);
      step();
    end
    bus.out_ready = 1'b0;
    check({tag, "_empty"}, int'(bus.out_valid), 0);
  endtask
  initial begin
    bus.out_ready = 1'b0;
    do_reset();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_ts", int'(bus.out_ts), 0);
    check("rst_level", int'(level), 0);
    check("rst_drop", int'(drop_cnt), 0);
    check("rst_ovf", int'(overflow), 0);
    bus.out_ready = 1'b1;
    step(10);
    check("idle_valid", int'(bus.out_valid), 0);
    check("idle_ts", int'(bus.out_ts), 0);
    check("idle_level", int'(level), 0);
    do_reset();
    step(5);
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    check("single_valid", int'(bus.out_valid), 1);
    check("single_ts", int'(bus.out_ts), 5);
    check("single_level", int'(level), 1);
    step(2);
    check("single_hold_ts", int'(bus.out_ts), 5);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("single_pop_level", int'(level), 0);
    check("single_pop_valid", int'(bus.out_valid), 0);
    check("single_pop_ts", int'(bus.out_ts), 0);
    do_reset();
    spike_in = 1'b1;
    step(10);
    spike_in = 1'b0;
    check("fill_level", int'(level), 8);
    check("fill_drop", int'(drop_cnt), 2);
    check("fill_ovf", int'(overflow), 1);
    drain("fill_drain", OLD, 8);
    do_reset();
    spike_in = 1'b1;
    step(8);
    check("full_level", int'(level), 8);
    bus.out_ready = 1'b1;
    step();
    spike_in = 1'b0;
    bus.out_ready = 1'b0;
    check("pp_level", int'(level), 8);
    check("pp_drop", int'(drop_cnt), 0);
    check("pp_ovf", int'(overflow), 0);
    drain("pp_drain", 1, 8);
    do_reset();
    step(15);
    spike_in = 1'b1;
    step(2);
    spike_in = 1'b0;
    check("wrap_level", int'(level), 2);
    drain("wrap_drain", 15, 2);
    do_reset();
    spike_in = 1'b1;
    step(10);
    check("clr_pre_drop", int'(drop_cnt), 2);
    clr_drop = 1'b1;
    step();
    check("clr_coll_drop", int'(drop_cnt), 1);
    check("clr_coll_ovf", int'(overflow), 1);
    clr_drop = 1'b0;
    step(260);
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_level", int'(level), 8);
    spike_in = 1'b0;
    clr_drop = 1'b1;
    step();
    clr_drop = 1'b0;
    check("clr_drop", int'(drop_cnt), 0);
    check("clr_ovf", int'(overflow), 0);
    do_reset();
    spike_in = 1'b1;
    step(3);
    spike_in = 1'b0;
    check("mid_level", int'(level), 3);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_ts", int'(bus.out_ts), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_drop", int'(drop_cnt), 0);
    check("mid_rst_ovf", int'(overflow), 0);
    bus.out_ready = 1'b0;
    step(3);
    spike_in = 1'b1;
    step();
    spike_in = 1'b0;
    check("post_rst_ts", int'(bus.out_ts), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
